// File: rtl/keypad_scan.sv
// Matrix keypad scanner for a 3-column x 4-row keypad: drives one column at a time,
// classifies each 3-column frame, debounces over whole frames and emits one strobe per press.
module keypad_scan #(
  parameter int SCAN_DIV   = 25000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       col_idx;
  logic [1:0]       acc_hits;   // hits so far in this frame, 2 means "two or more"
  logic [3:0]       acc_code;
  logic [2:0]       col_hits;
  logic [3:0]       col_code;
  logic [2:0]       hit_sum;
  logic [1:0]       frame_hits;
  logic [3:0]       frame_code;
  logic             frame_end;
  logic             frame_single, frame_none;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt, rcnt, rcnt_nxt, cand, cand_nxt;
  logic       accept, release_key;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    if (r != 2'd3) return 4'(3 * r + c + 1);
    case (c)
      2'd0:    return 4'd10;
      2'd1:    return 4'd0;
      default: return 4'd11;
    endcase
  endfunction

  assign tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = tick && (col_idx == 2'd2);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
      div_cnt  <= '0;
      col_idx  <= '0;
      acc_hits <= '0;
      acc_code <= '0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
      if (tick) begin
        div_cnt  <= '0;
        col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        acc_hits <= frame_hits;
        acc_code <= frame_code;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int r = 0; r < 4; r++) begin
      if (row_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_code(2'(r), col_idx);
      end
    end
    // Column 0 opens a fresh frame, so earlier accumulation is ignored there.
    hit_sum      = ((col_idx == 2'd0) ? 3'd0 : {1'b0, acc_hits}) + col_hits;
    frame_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code   = (col_hits == 3'd1) ? col_code : acc_code;
    frame_single = (frame_hits == 2'd1);
    frame_none   = (frame_hits == 2'd0);
  end

  always_comb begin
    case (col_idx)
      2'd1:    key_col = 3'b101;
      2'd2:    key_col = 3'b011;
      default: key_col = 3'b110;
    endcase
  end

  // State register, including the registered outputs that change on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      cand      <= '0;
      key_data  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rcnt      <= rcnt_nxt;
      cand      <= cand_nxt;
      key_valid <= accept;
      if (accept) begin
        key_data <= cand_nxt;
        key_held <= 1'b1;
      end else if (release_key) begin
        key_held <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    cand_nxt  = cand;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_single) begin
            cand_nxt = frame_code;
            if (DEBOUNCE_N == 1) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
              rcnt_nxt  = '0;
            end else begin
              state_nxt = DEBOUNCE;
              cnt_nxt   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_single && frame_code == cand) begin
            if (cnt + 4'd1 == 4'(DEBOUNCE_N)) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
              rcnt_nxt  = '0;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        HELD: begin
          if (frame_none) begin
            if (rcnt + 4'd1 == 4'(DEBOUNCE_N)) begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + 4'd1;
            end
          end else begin
            rcnt_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    accept      = (state != HELD) && (state_nxt == HELD);
    release_key = (state == HELD) && (state_nxt == IDLE);
  end

endmodule
